psram_req_arbiter: RTL and testbench
====================================

// Module: psram_req_arbiter
// PURPOSE
//  Three-requester scheduler in front of psram_ctrlr: video pipeline burst reads (V), processor
//  single-word accesses (P) and a UART loader DMA port (D). Issues one controller op at a time,
//  tracks it to completion, routes data_ok/rd_data to the owner, reports lost ops via timeout.
//  Sits between video_pipeline / mem_map_io / loader and psram_ctrlr on clk (100 MHz).
// PARAMETERS
//  BURST_LEN   16    data_ok beats expected per V burst read
//  TIMEOUT     255   cycles allowed from strobe to op_begun before abort
//  CNT_W       8     width of beat and timeout counters
// PORTS
//  clk          in   1   system clock, 100 MHz
//  clr_n        in   1   synchronous active-low reset
//  ctrl_good    in   1   controller initialised; no grant while low
//  v_req        in   1   V burst read request, level, held until v_done
//  v_addr       in   23  V burst start address
//  v_data_ok    out  1   V beat valid (pass-through of data_ok while V owns bus)
//  v_done       out  1   V op complete, 1-cycle pulse
//  p_req/d_req  in   1   P/D request, level, held until done
//  p_wr/d_wr    in   1   1=write, 0=read; sampled with req in IDLE
//  p_addr/d_addr in  23  word address
//  p_wdata/d_wdata in 16 write data
//  p_rdata/d_rdata out 16 read data, valid from done pulse until next own read completes
//  p_done/d_done out 1   op complete, 1-cycle pulse
//  p_stall      out  1   high while p_req and P op not yet done
//  err          out  1   sticky: a timeout occurred; cleared only by reset
//  op_begun, data_ok, op_finished  in 1  controller status
//  rd_data      in   16  controller read data
//  app_addr     out  23  registered op address
//  app_data_out out  16  registered write data
//  app_rd/app_wr/app_burst out 1  controller strobes
// BEHAVIOUR
//  Reset (clr_n=0 at clk edge): state IDLE; all outputs 0; rr_ptr=P; counters 0; err=0.
//  States: IDLE -> ISSUE -> WAIT_BEGUN -> XFER -> DONE -> IDLE; WAIT_BEGUN -> ABORT -> IDLE.
//  IDLE: if ctrl_good: V wins if v_req; else P vs D round-robin: if both, the one not equal
//   rr_ptr wins; if one, it wins. Capture owner, addr, wdata, wr. Nothing requested: stay.
//  ISSUE (1 cycle): app_rd or app_wr =1 per captured wr; app_burst=1 only for V. Strobes are
//   1-cycle pulses. Latency: req seen in IDLE at edge n -> strobe high in cycle n+1.
//  WAIT_BEGUN: op_begun -> XFER, timeout counter cleared. Counter hits TIMEOUT -> ABORT.
//  XFER: each data_ok: V -> v_data_ok=1 same cycle (combinational gate), beat_cnt+1;
//   P/D read -> capture rd_data into own rdata reg. op_finished -> DONE. For V, op_finished
//   with beat_cnt != BURST_LEN sets err. Beats beyond BURST_LEN still forwarded.
//  DONE (1 cycle): owner's done pulse; if owner P/D, rr_ptr <= owner; beat_cnt <= 0.
//  ABORT (1 cycle): err <= 1; owner's done pulse; rdata unchanged; rr_ptr updated as DONE.
//  app_addr/app_data_out hold last captured values outside ISSUE.
//  Edge cases: req dropped mid-op -> op still completes, done still pulses; op_begun/data_ok/
//   op_finished outside their states ignored; ctrl_good falling mid-op ignored (op finishes);
//   reset mid-op -> IDLE immediately, late controller status ignored; V may starve P/D by design
//   (video has absolute priority, requests once per line-buffer refill).
//  Widths: beat_cnt and timeout counter CNT_W bits, saturating; BURST_LEN, TIMEOUT < 2**CNT_W.
// STRUCTURE
//  Shared package/header psram_arb_defs: state encodings (IDLE..ABORT), owner codes
//   OWN_V/OWN_P/OWN_D, PSRAM_AW=23, PSRAM_DW=16.
//  One sub-module: arb_rr2 (two-way round-robin pick from p_req, d_req, rr_ptr). Rest flat.
// TESTING
//  1 Reset: clr_n=0 3 cycles mid-burst -> all outputs 0, IDLE; stray op_finished -> no done.
//  2 P write 0x000123<=0xBEEF: strobe app_wr cycle+1, app_addr=0x000123, op_begun@+3,
//    op_finished@+6 -> p_done 1 cycle later, p_stall low after done, err=0.
//  3 v_req and p_req same cycle -> V first: app_burst=1, 16 v_data_ok, v_done; then P issued.
//  4 p_req,d_req held continuously (reads) -> grants alternate P,D,P,D; p_rdata=rd_data per beat.
//  5 No op_begun after strobe -> ABORT at TIMEOUT(255) cycles, err=1 sticky, d_done pulses.
//  6 V burst with op_finished after 15 beats -> err=1, v_done pulses, next op proceeds.

Source files
------------

// File: rtl/psram_arb_defs.sv
// psram_arb_defs: shared FSM states, owner codes and bus widths for the PSRAM request arbiter.
package psram_arb_defs;
  localparam int PSRAM_AW = 23;
  localparam int PSRAM_DW = 16;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BEGUN, XFER, DONE, ABORT} state_e;
  typedef enum logic [1:0] {OWN_V, OWN_P, OWN_D} owner_e;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin pick between P and D; when both request, the one not last served wins.
module arb_rr2
  import psram_arb_defs::*;
(
  input  logic   p_req_i,
  input  logic   d_req_i,
  input  owner_e rr_ptr_i,
  output logic   any_o,
  output owner_e pick_o
);
  assign any_o  = p_req_i | d_req_i;
  assign pick_o = (p_req_i && d_req_i) ? ((rr_ptr_i == OWN_P) ? OWN_D : OWN_P)
                                       : (p_req_i ? OWN_P : OWN_D);
endmodule

// File: rtl/psram_req_arbiter.sv
// psram_req_arbiter: schedules video bursts, processor and loader-DMA ops onto psram_ctrlr one at a time,
// routes beats/read data to the owner and flags lost or short ops on a sticky err.
module psram_req_arbiter
  import psram_arb_defs::*;
#(
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                ctrl_good,
  input  logic                v_req,
  input  logic [PSRAM_AW-1:0] v_addr,
  output logic                v_data_ok,
  output logic                v_done,
  input  logic                p_req,
  input  logic                p_wr,
  input  logic [PSRAM_AW-1:0] p_addr,
  input  logic [PSRAM_DW-1:0] p_wdata,
  output logic [PSRAM_DW-1:0] p_rdata,
  output logic                p_done,
  output logic                p_stall,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [PSRAM_AW-1:0] d_addr,
  input  logic [PSRAM_DW-1:0] d_wdata,
  output logic [PSRAM_DW-1:0] d_rdata,
  output logic                d_done,
  output logic                err,
  input  logic                op_begun,
  input  logic                data_ok,
  input  logic                op_finished,
  input  logic [PSRAM_DW-1:0] rd_data,
  output logic [PSRAM_AW-1:0] app_addr,
  output logic [PSRAM_DW-1:0] app_data_out,
  output logic                app_rd,
  output logic                app_wr,
  output logic                app_burst
);
  state_e              state_q;
  owner_e              owner_q, rr_ptr_q, rr_pick;
  logic                rr_any, wr_q, grant_wr;
  logic                app_rd_q, app_wr_q, app_burst_q, v_done_q, p_done_q, d_done_q, err_q;
  logic [CNT_W-1:0]    beat_cnt_q, tmo_q, beat_inc;
  logic [PSRAM_AW-1:0] app_addr_q;
  logic [PSRAM_DW-1:0] app_data_q, p_rdata_q, d_rdata_q;
  logic [2:0]          own_done;

  arb_rr2 u_rr (.p_req_i(p_req), .d_req_i(d_req), .rr_ptr_i(rr_ptr_q), .any_o(rr_any), .pick_o(rr_pick));

  assign grant_wr = !v_req && ((rr_pick == OWN_P) ? p_wr : d_wr);
  assign beat_inc = (data_ok && beat_cnt_q != '1) ? beat_cnt_q + 1'b1 : beat_cnt_q;
  assign own_done = {owner_q == OWN_D, owner_q == OWN_P, owner_q == OWN_V};

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      owner_q <= OWN_V;
      rr_ptr_q <= OWN_P;
      wr_q <= 1'b0;
      {app_rd_q, app_wr_q, app_burst_q, v_done_q, p_done_q, d_done_q, err_q} <= '0;
      beat_cnt_q <= '0;
      tmo_q <= '0;
      app_addr_q <= '0;
      app_data_q <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      {app_rd_q, app_wr_q, app_burst_q, v_done_q, p_done_q, d_done_q} <= '0;
      case (state_q)
        IDLE: if (ctrl_good && (v_req || rr_any)) begin
          state_q <= ISSUE;
          owner_q <= v_req ? OWN_V : rr_pick;
          wr_q <= grant_wr;
          app_rd_q <= !grant_wr;
          app_wr_q <= grant_wr;
          app_burst_q <= v_req;
          app_addr_q <= v_req ? v_addr : ((rr_pick == OWN_P) ? p_addr : d_addr);
          if (!v_req) app_data_q <= (rr_pick == OWN_P) ? p_wdata : d_wdata;
        end
        ISSUE: begin
          state_q <= WAIT_BEGUN;
          tmo_q <= '0;
        end
        WAIT_BEGUN: if (op_begun) begin
          state_q <= XFER;
          tmo_q <= '0;
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          state_q <= ABORT;
          err_q <= 1'b1;
          {d_done_q, p_done_q, v_done_q} <= own_done;
        end else if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
        XFER: begin
          if (owner_q == OWN_V) beat_cnt_q <= beat_inc;
          else if (data_ok && !wr_q && owner_q == OWN_P) p_rdata_q <= rd_data;
          else if (data_ok && !wr_q) d_rdata_q <= rd_data;
          if (op_finished) begin
            state_q <= DONE;
            {d_done_q, p_done_q, v_done_q} <= own_done;
            // A burst that ends with the wrong beat count means the line buffer is corrupt.
            if (owner_q == OWN_V && beat_inc != CNT_W'(BURST_LEN)) err_q <= 1'b1;
          end
        end
        DONE, ABORT: begin
          state_q <= IDLE;
          beat_cnt_q <= '0;
          if (owner_q != OWN_V) rr_ptr_q <= owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign v_data_ok    = data_ok && state_q == XFER && owner_q == OWN_V;
  assign v_done       = v_done_q;
  assign p_done       = p_done_q;
  assign d_done       = d_done_q;
  assign p_stall      = p_req & ~p_done_q;
  assign p_rdata      = p_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign err          = err_q;
  assign app_addr     = app_addr_q;
  assign app_data_out = app_data_q;
  assign app_rd       = app_rd_q;
  assign app_wr       = app_wr_q;
  assign app_burst    = app_burst_q;
endmodule

// File: tb/tb_psram_req_arbiter.sv
// tb_psram_req_arbiter: directed and randomized ops against a transaction-level model of grant order,
// strobes, beat routing, read data and error reporting.
module tb_psram_req_arbiter;
  localparam int BL = 16;
  localparam int TO = 255;
  logic clk = 0, clr_n = 0, ctrl_good = 0;
  logic v_req = 0, p_req = 0, d_req = 0, p_wr = 0, d_wr = 0;
  logic [22:0] v_addr = 0, p_addr = 0, d_addr = 0;
  logic [15:0] p_wdata = 0, d_wdata = 0, rd_data = 0;
  logic op_begun = 0, data_ok = 0, op_finished = 0;
  logic v_data_ok, v_done, p_done, d_done, p_stall, err, app_rd, app_wr, app_burst;
  logic [15:0] p_rdata, d_rdata, app_data_out;
  logic [22:0] app_addr;
  int n_chk = 0, n_pass = 0;
  int rr = 1;
  bit m_err = 0;
  logic [15:0] m_prd = 0, m_drd = 0;

  psram_req_arbiter dut (
    .clk(clk), .clr_n(clr_n), .ctrl_good(ctrl_good),
    .v_req(v_req), .v_addr(v_addr), .v_data_ok(v_data_ok), .v_done(v_done),
    .p_req(p_req), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata),
    .p_done(p_done), .p_stall(p_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .err(err), .op_begun(op_begun), .data_ok(data_ok), .op_finished(op_finished), .rd_data(rd_data),
    .app_addr(app_addr), .app_data_out(app_data_out), .app_rd(app_rd), .app_wr(app_wr), .app_burst(app_burst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick();
    if (v_req) return 0;
    if (p_req && d_req) return (rr == 1) ? 2 : 1;
    return p_req ? 1 : 2;
  endfunction

  task automatic do_reset();
    clr_n = 0;
    {op_begun, data_ok, op_finished} = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {app_rd, app_wr, app_burst, v_data_ok, v_done, p_done, d_done, err}, 0);
    check("rst_bus", {app_addr, app_data_out}, 0);
    check("rst_rdata", {p_rdata, d_rdata}, 0);
    clr_n = 1;
    rr = 1;
    m_err = 0;
    m_prd = 0;
    m_drd = 0;
  endtask

  // Serve one op as the controller would; vb = beats for a V burst, begun=0 withholds op_begun.
  task automatic serve(input int vb, input bit begun, output int own);
    int t, beats, vcnt;
    logic wr;
    logic [22:0] addr;
    logic [15:0] wdata;
    own   = pick();
    wr    = (own == 1) ? p_wr : (own == 2) ? d_wr : 1'b0;
    addr  = (own == 1) ? p_addr : (own == 2) ? d_addr : v_addr;
    wdata = (own == 1) ? p_wdata : d_wdata;
    beats = (own == 0) ? vb : (wr ? 0 : int'($urandom_range(1, 2)));
    t = 0;
    while (!(app_rd || app_wr) && t < 20) begin @(negedge clk); t++; end
    check("strobe_seen", 32'(t < 20), 1);
    if (t >= 20) return;
    check("app_wr", app_wr, wr);
    check("app_rd", app_rd, !wr);
    check("app_burst", app_burst, own == 0);
    check("app_addr", app_addr, addr);
    if (own != 0) check("app_data", app_data_out, wdata);
    check("p_stall_busy", p_stall, p_req);
    @(negedge clk);
    check("strobe_pulse", {app_rd, app_wr, app_burst}, 0);
    if (!begun) begin
      t = 1;
      while (!(v_done || p_done || d_done) && t < 400) begin @(negedge clk); t++; end
      check("tmo_cycles", t, TO + 1);
      m_err = 1;
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op_begun = 1;
      @(negedge clk);
      op_begun = 0;
      vcnt = 0;
      for (int i = 0; i < beats; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        data_ok = 1;
        rd_data = 16'($urandom);
        #1;
        if (v_data_ok) vcnt++;
        if (own == 1 && !wr) m_prd = rd_data;
        if (own == 2 && !wr) m_drd = rd_data;
        @(negedge clk);
        data_ok = 0;
      end
      op_finished = 1;
      @(negedge clk);
      op_finished = 0;
      check("v_beats", vcnt, (own == 0) ? beats : 0);
      if (own == 0 && beats != BL) m_err = 1;
    end
    check("done_vec", {v_done, p_done, d_done}, {own == 0, own == 1, own == 2});
    check("p_rdata", p_rdata, m_prd);
    check("d_rdata", d_rdata, m_drd);
    check("err", err, m_err);
    if (own == 1) check("p_stall_done", p_stall, 0);
    if (own != 0) rr = own;
    @(negedge clk);
    check("done_pulse", {v_done, p_done, d_done}, 0);
  endtask

  initial begin
    int own;
    @(negedge clk);
    do_reset();
    // Mid-burst reset: late controller status must be ignored afterwards.
    ctrl_good = 1;
    v_req = 1;
    v_addr = 23'h40000;
    repeat (3) @(negedge clk);
    op_begun = 1;
    @(negedge clk);
    op_begun = 0;
    data_ok = 1;
    repeat (5) @(negedge clk);
    v_req = 0;
    do_reset();
    op_finished = 1;
    data_ok = 1;
    #1 check("stray_vok", v_data_ok, 0);
    @(negedge clk);
    {op_finished, data_ok} = '0;
    check("stray_done", {v_done, p_done, d_done, app_rd, app_wr}, 0);
    // No grant while controller not ready.
    ctrl_good = 0;
    p_req = 1;
    repeat (3) @(negedge clk);
    check("no_grant_ctrl_bad", {app_rd, app_wr}, 0);
    p_req = 0;
    ctrl_good = 1;
    @(negedge clk);
    // P write with exact one-cycle strobe latency.
    p_req = 1; p_wr = 1; p_addr = 23'h000123; p_wdata = 16'hBEEF;
    @(negedge clk);
    check("lat_p_wr", app_wr, 1);
    serve(BL, 1, own);
    p_req = 0;
    // V and P together: V first, then P.
    v_req = 1; v_addr = 23'h7F000; p_req = 1; p_wr = 0; p_addr = 23'h00555;
    serve(BL, 1, own);
    check("v_first", own, 0);
    v_req = 0;
    serve(BL, 1, own);
    check("p_after_v", own, 1);
    // P and D held continuously: grants alternate.
    d_req = 1; d_wr = 0;
    for (int i = 0; i < 6; i++) begin
      serve(BL, 1, own);
      check("alt_owner", own, (i % 2 == 0) ? 2 : 1);
      if (own == 1) p_addr = 23'($urandom); else d_addr = 23'($urandom);
    end
    p_req = 0; d_req = 0;
    // D write never begun: timeout abort, sticky err.
    d_req = 1; d_wr = 1; d_addr = 23'h1ABCD; d_wdata = 16'h1234;
    serve(BL, 0, own);
    d_req = 0;
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    // Short burst on a clean error flag, then normal traffic continues.
    do_reset();
    v_req = 1; v_addr = 23'h00100;
    serve(BL - 1, 1, own);
    v_req = 0;
    p_req = 1; p_wr = 0;
    serve(BL, 1, own);
    check("p_after_short", own, 1);
    p_req = 0;
    // Randomized mix.
    for (int i = 0; i < 20; i++) begin
      if (!p_req && $urandom_range(0, 1) == 1) begin
        p_req = 1; p_wr = 1'($urandom); p_addr = 23'($urandom); p_wdata = 16'($urandom);
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1; d_wr = 1'($urandom); d_addr = 23'($urandom); d_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin v_req = 1; v_addr = 23'($urandom); end
      if (!(p_req || d_req || v_req)) begin p_req = 1; p_wr = 0; p_addr = 23'($urandom); end
      serve(($urandom_range(0, 3) == 0) ? BL + 1 : BL, 1, own);
      if (own == 0) v_req = 0;
      else if (own == 1) p_req = 0;
      else d_req = 0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
